// File: rtl/byteswap_pkg.sv
// Shared definitions for the byteswap stream arbiter and its picker.
// Holds the FSM encoding and the constant helpers used for parameter checks.
package byteswap_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  function automatic bit id_width_ok(input int num_ports, input int id_width);
    return id_width >= clog2(num_ports);
  endfunction

endpackage

// File: rtl/byteswap_rr_picker.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
// Also intended for reuse by the swapped-result demux.
module byteswap_rr_picker
  import byteswap_pkg::*;
#(
  parameter int C_NUM_PORTS = 4,
  parameter int C_IDX_WIDTH = 4
) (
  input  logic [C_NUM_PORTS-1:0] req,
  input  logic [C_IDX_WIDTH-1:0] last_grant,
  output logic                   any,
  output logic [C_IDX_WIDTH-1:0] next_grant
);

  localparam int N  = C_NUM_PORTS;
  localparam int SW = C_IDX_WIDTH + 1;

  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [SW-1:0]  base;
  logic [SW-1:0]  first;
  logic [SW-1:0]  sum;
  logic           found;

  // rotated[i] is the request of port (last_grant + 1 + i) mod N
  assign doubled = {req, req};
  assign base    = {1'b0, last_grant} + SW'(1);
  assign rotated = N'(doubled >> base);
  assign any     = |req;

  always_comb begin
    found = 1'b0;
    first = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && rotated[i]) begin
        found = 1'b1;
        first = SW'(i);
      end
    end
  end

  assign sum        = base + first;
  assign next_grant = (sum >= SW'(N)) ? C_IDX_WIDTH'(sum - SW'(N)) : C_IDX_WIDTH'(sum);

endmodule

// File: rtl/byteswap_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one swapper stream between ports.
// Grant is held from first beat to tlast; each forwarded beat carries its port id.
module byteswap_stream_arbiter
  import byteswap_pkg::*;
#(
  parameter int C_NUM_PORTS        = 4,
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ID_WIDTH         = 4
) (
  input  logic                                        aclk,
  input  logic                                        areset_n,
  input  logic                                        ctrl_enable,
  input  logic [C_NUM_PORTS-1:0]                      s_axis_tvalid,
  output logic [C_NUM_PORTS-1:0]                      s_axis_tready,
  input  logic [C_NUM_PORTS*C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_NUM_PORTS*C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [C_NUM_PORTS-1:0]                      s_axis_tlast,
  output logic                                        m_axis_tvalid,
  input  logic                                        m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]               m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]             m_axis_tkeep,
  output logic                                        m_axis_tlast,
  output logic [C_ID_WIDTH-1:0]                       m_axis_tid,
  output logic                                        stat_busy
);

  localparam int NP = C_NUM_PORTS;
  localparam int W  = C_AXIS_TDATA_WIDTH;
  localparam int KW = C_AXIS_TDATA_WIDTH / 8;

  if (!id_width_ok(NP, C_ID_WIDTH)) begin : g_bad_id_width
    $error("C_ID_WIDTH too narrow for C_NUM_PORTS");
  end
  if (NP < 2 || NP > 16) begin : g_bad_num_ports
    $error("C_NUM_PORTS must be in 2..16");
  end
  if ((W % 32) != 0) begin : g_bad_data_width
    $error("C_AXIS_TDATA_WIDTH must be a multiple of 32");
  end

  arb_state_t            state_reg, state_next;
  logic [C_ID_WIDTH-1:0] grant_reg, grant_next;
  logic [C_ID_WIDTH-1:0] last_grant_reg, last_grant_next;

  logic                  pick_any;
  logic [C_ID_WIDTH-1:0] pick_grant;
  logic [NP-1:0]         grant_onehot;
  logic                  locked;
  logic                  out_ready;
  logic                  accept;

  logic                  sel_valid;
  logic                  sel_last;
  logic [W-1:0]          sel_data;
  logic [KW-1:0]         sel_keep;

  byteswap_rr_picker #(
    .C_NUM_PORTS (NP),
    .C_IDX_WIDTH (C_ID_WIDTH)
  ) u_picker (
    .req        (s_axis_tvalid),
    .last_grant (last_grant_reg),
    .any        (pick_any),
    .next_grant (pick_grant)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_onehot
      assign grant_onehot[gi] = (grant_reg == C_ID_WIDTH'(gi));
    end
  endgenerate

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    for (int p = 0; p < NP; p++) begin
      if (grant_onehot[p]) begin
        sel_valid = s_axis_tvalid[p];
        sel_last  = s_axis_tlast[p];
        sel_data  = s_axis_tdata[p*W +: W];
        sel_keep  = s_axis_tkeep[p*KW +: KW];
      end
    end
  end

  // The output register can take a beat when empty or draining this cycle
  assign locked        = (state_reg == ST_LOCKED);
  assign out_ready     = m_axis_tready | ~m_axis_tvalid;
  assign s_axis_tready = (locked && out_ready) ? grant_onehot : '0;
  assign accept        = locked & out_ready & sel_valid;
  assign stat_busy     = locked | m_axis_tvalid;

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      ST_IDLE: begin
        if (ctrl_enable && pick_any) begin
          state_next = ST_LOCKED;
          grant_next = pick_grant;
        end
      end
      ST_LOCKED: begin
        if (accept && sel_last) begin
          state_next      = ST_IDLE;
          last_grant_next = grant_reg;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // last_grant starts at the top port so port 0 wins the first search
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= '0;
      last_grant_reg <= C_ID_WIDTH'(NP - 1);
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
    end else if (accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= sel_data;
      m_axis_tkeep  <= sel_keep;
      m_axis_tlast  <= sel_last;
      m_axis_tid    <= grant_reg;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_byteswap_stream_arbiter.sv
// Scoreboard bench for byteswap_stream_arbiter: per-port producer queues feed the
// DUT, expected output beats (with optional exact cycle) are queued up front.
module tb_byteswap_stream_arbiter;

  localparam int NP = 4;
  localparam int W  = 32;
  localparam int KW = W / 8;
  localparam int IW = 4;

  logic              aclk = 1'b0;
  logic              areset_n;
  logic              ctrl_enable;
  logic [NP-1:0]     s_axis_tvalid;
  logic [NP-1:0]     s_axis_tready;
  logic [NP*W-1:0]   s_axis_tdata;
  logic [NP*KW-1:0]  s_axis_tkeep;
  logic [NP-1:0]     s_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [W-1:0]      m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic              m_axis_tlast;
  logic [IW-1:0]     m_axis_tid;
  logic              stat_busy;

  always #5 aclk = ~aclk;

  byteswap_stream_arbiter #(
    .C_NUM_PORTS        (NP),
    .C_AXIS_TDATA_WIDTH (W),
    .C_ID_WIDTH         (IW)
  ) dut (
    .aclk          (aclk),
    .areset_n      (areset_n),
    .ctrl_enable   (ctrl_enable),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .stat_busy     (stat_busy)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  typedef struct {
    logic [IW-1:0] tid;
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic          last;
    int            cyc;
  } exp_t;

  beat_t pq[NP][$];
  exp_t  sb[$];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic        stall_prev = 1'b0;
  logic [63:0] held = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [KW-1:0] keep_of(input logic [W-1:0] d);
    return d[KW-1:0] | KW'(1);
  endfunction

  function automatic bit any_pq();
    bit r = 1'b0;
    for (int p = 0; p < NP; p++) if (pq[p].size() > 0) r = 1'b1;
    return r;
  endfunction

  task automatic push_beat(input int port, input logic [W-1:0] data, input logic last, input int ecyc);
    beat_t b;
    exp_t  e;
    b.data = data;
    b.last = last;
    pq[port].push_back(b);
    e.tid  = IW'(port);
    e.data = data;
    e.keep = keep_of(data);
    e.last = last;
    e.cyc  = ecyc;
    sb.push_back(e);
  endtask

  // first_cyc < 0 means "don't check timing"; otherwise beats are consecutive
  task automatic send_packet(input int port, input int n, input logic [W-1:0] base, input int first_cyc);
    for (int i = 0; i < n; i++) begin
      push_beat(port, base + W'(i * 32'h11), (i == n - 1), (first_cyc < 0) ? -1 : first_cyc + i);
    end
  endtask

  // One clock: drive queue heads, sample mid-cycle, advance to #1 after the edge
  task automatic step();
    logic [NP-1:0] hs;
    exp_t          e;
    for (int p = 0; p < NP; p++) begin
      if (pq[p].size() > 0) begin
        s_axis_tvalid[p]         = 1'b1;
        s_axis_tdata[p*W +: W]   = pq[p][0].data;
        s_axis_tkeep[p*KW +: KW] = keep_of(pq[p][0].data);
        s_axis_tlast[p]          = pq[p][0].last;
      end else begin
        s_axis_tvalid[p]         = 1'b0;
        s_axis_tdata[p*W +: W]   = '0;
        s_axis_tkeep[p*KW +: KW] = '0;
        s_axis_tlast[p]          = 1'b0;
      end
    end
    #4;
    if (areset_n) begin
      check("rdy_onehot0", ($countones(s_axis_tready) <= 1), 1);
      if (m_axis_tvalid && !m_axis_tready) check("rdy_stall", s_axis_tready, 0);
      if (stall_prev)
        check("hold", {m_axis_tvalid, m_axis_tid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, held);
      if (m_axis_tvalid && m_axis_tready) begin
        check("beat_expected", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          $display("beat cyc=%0d tid=%0d data=0x%08h keep=0x%0h last=%0b", cyc, m_axis_tid,
                   m_axis_tdata, m_axis_tkeep, m_axis_tlast);
          check("out_tid", m_axis_tid, e.tid);
          check("out_data", m_axis_tdata, e.data);
          check("out_keep", m_axis_tkeep, e.keep);
          check("out_last", m_axis_tlast, e.last);
          if (e.cyc >= 0) check("out_cycle", cyc, e.cyc);
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      held = 64'({m_axis_tvalid, m_axis_tid, m_axis_tlast, m_axis_tkeep, m_axis_tdata});
    end else begin
      stall_prev = 1'b0;
    end
    hs = s_axis_tvalid & s_axis_tready;
    @(posedge aclk);
    #1;
    cyc++;
    for (int p = 0; p < NP; p++) begin
      if (hs[p] && pq[p].size() > 0) void'(pq[p].pop_front());
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() > 0 || any_pq()) && n < budget) begin
      step();
      n++;
    end
    check("drain_done", sb.size(), 0);
  endtask

  task automatic do_reset();
    for (int p = 0; p < NP; p++) pq[p].delete();
    sb.delete();
    areset_n = 1'b0;
    step();
    areset_n = 1'b1;
    stall_prev = 1'b0;
  endtask

  initial begin
    int k0;
    areset_n      = 1'b0;
    ctrl_enable   = 1'b1;
    m_axis_tready = 1'b1;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = '0;

    do_reset();
    check("rst_mvalid", m_axis_tvalid, 0);
    check("rst_ready", s_axis_tready, 0);
    check("rst_busy", stat_busy, 0);
    check("rst_tid", m_axis_tid, 0);

    // Lone requester: port 2, 3 beats, first output two cycles after tvalid
    k0 = cyc;
    send_packet(2, 3, 32'h11, k0 + 2);
    step();
    step();
    check("t1_busy", stat_busy, 1);
    drain(20);

    // Four competing 2-beat packets: 0,1,2,3 with one idle cycle between
    do_reset();
    k0 = cyc;
    for (int p = 0; p < NP; p++) send_packet(p, 2, 32'hA000_0000 + W'(p << 8), k0 + 2 + 3 * p);
    drain(40);

    // Backpressure 1,0,0,1 across a 4-beat packet on port 1
    do_reset();
    k0 = cyc;
    push_beat(1, 32'hB000_0001, 1'b0, k0 + 2);
    push_beat(1, 32'hB000_0002, 1'b0, k0 + 5);
    push_beat(1, 32'hB000_0003, 1'b0, k0 + 6);
    push_beat(1, 32'hB000_0004, 1'b1, k0 + 7);
    for (int i = 0; i < 10; i++) begin
      m_axis_tready = !((cyc == k0 + 3) || (cyc == k0 + 4));
      step();
    end
    m_axis_tready = 1'b1;
    drain(10);

    // ctrl_enable drops while port 1 is mid-packet and port 3 waits
    do_reset();
    send_packet(1, 4, 32'hC100_0000, -1);
    step();
    ctrl_enable = 1'b0;
    send_packet(3, 2, 32'hC300_0000, -1);
    repeat (10) step();
    check("t4_port1_done", pq[1].size(), 0);
    check("t4_port3_waiting", pq[3].size(), 2);
    check("t4_idle_ready", s_axis_tready, 0);
    ctrl_enable = 1'b1;
    drain(20);

    // Reset during beat 2 of a 5-beat packet; next grant must be port 0
    do_reset();
    send_packet(0, 1, 32'hD000_0000, -1);
    drain(10);
    send_packet(2, 5, 32'hD200_0000, -1);
    repeat (3) step();
    areset_n = 1'b0;
    step();
    areset_n = 1'b1;
    for (int p = 0; p < NP; p++) pq[p].delete();
    sb.delete();
    stall_prev = 1'b0;
    check("t5_mvalid", m_axis_tvalid, 0);
    check("t5_ready", s_axis_tready, 0);
    k0 = cyc;
    send_packet(0, 1, 32'hD0D0_0000, k0 + 2);
    send_packet(2, 1, 32'hD2D2_0000, k0 + 4);
    drain(20);

    // last_grant=0, single-beat packets on ports 0 and 3: port 3 first
    do_reset();
    send_packet(0, 1, 32'hE000_0000, -1);
    drain(10);
    k0 = cyc;
    send_packet(3, 1, 32'hE300_0000, k0 + 2);
    send_packet(0, 1, 32'hE0E0_0000, k0 + 4);
    drain(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
